// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM library packer/unpacker pair.
// Holds the FSM state encoding, a constant clog2 and the width-ratio check
// that both the narrow-to-wide writer and the wide-to-narrow reader use.
package bram_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Word must hold a whole number (>= 2) of narrow beats.
  function automatic bit ratio_ok(input int in_w, input int word_w);
    return (in_w > 0) && ((word_w % in_w) == 0) && ((word_w / in_w) >= 2);
  endfunction

endpackage

// File: rtl/bram_stream_packer_if.sv
// Bus bundle for bram_stream_packer: the narrow valid/ready input stream
// and the BRAM write port.
//   in_data/in_valid/in_last : narrow beat from the producer
//   in_ready                 : packer accepts the beat
//   bram_wr/addr/data        : one-cycle write strobe, address, wide word
// master = producer / memory side, slave = the packer itself.
interface bram_stream_packer_if #(
  parameter int IN_WIDTH   = 2,
  parameter int WORD_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  bram_wr;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [WORD_WIDTH-1:0] bram_data;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, bram_wr, bram_addr, bram_data
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, bram_wr, bram_addr, bram_data
  );
endinterface

// File: rtl/bram_stream_packer_slice_demux.sv
// slice_demux: combinational insert of one narrow beat into a wide word.
//   word_i : current word
//   data_i : narrow beat
//   sel_i  : slice index (0 = LSBs)
//   word_o : word_i with slice sel_i replaced by data_i
module slice_demux
  import bram_pkg::*;
#(
  parameter int IN_WIDTH   = 2,
  parameter int WORD_WIDTH = 4,
  localparam int RATIO     = WORD_WIDTH / IN_WIDTH,
  localparam int SEL_W     = (clog2(RATIO) < 1) ? 1 : clog2(RATIO)
) (
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WORD_WIDTH-1:0] word_o
);
  always_comb begin
    word_o = word_i;
    for (int k = 0; k < RATIO; k++) begin
      if (sel_i == SEL_W'(k)) word_o[k*IN_WIDTH +: IN_WIDTH] = data_i;
    end
  end
endmodule

// File: rtl/bram_stream_packer.sv
// bram_stream_packer: packs a narrow valid/ready stream into wide words and
// writes them to a BRAM from address 0 upward, one word per write.
//   clk, rst       : clock, async active-high reset
//   start_i        : arms a new fill (honoured in IDLE and DONE only)
//   bus (slave)    : input stream + BRAM write port
//   done_o         : fill finished, held until next start
//   full_o         : fill ended on the last address without in_last
//   word_count_o   : words written since the last start
module bram_stream_packer
  import bram_pkg::*;
#(
  parameter int IN_WIDTH   = 2,
  parameter int WORD_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  bram_stream_packer_if.slave   bus,
  output logic                  done_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   word_count_o
);
  localparam int RATIO = WORD_WIDTH / IN_WIDTH;
  localparam int SEL_W = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [SEL_W-1:0]      LAST_SEL  = SEL_W'(RATIO - 1);

  if (!ratio_ok(IN_WIDTH, WORD_WIDTH)) begin : g_bad_ratio
    $error("WORD_WIDTH must be an integer multiple (>=2) of IN_WIDTH");
  end

  logic [1:0]            state_q, state_d;
  logic [SEL_W-1:0]      slice_q, slice_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;   // fill ended on LAST_ADDR without in_last

  logic                  in_ready, accept, complete;
  logic [WORD_WIDTH-1:0] word_ins;

  slice_demux #(.IN_WIDTH(IN_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_demux (
    .word_i (asm_q),
    .data_i (bus.in_data),
    .sel_i  (slice_q),
    .word_o (word_ins)
  );

  assign in_ready = (state_q == S_FILL);
  assign accept   = bus.in_valid & in_ready;
  assign complete = accept & ((slice_q == LAST_SEL) | bus.in_last);

  always_comb begin
    state_d = state_q;
    slice_d = slice_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    full_d  = full_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_FILL;
          slice_d = '0;
          asm_d   = '0;
          addr_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          full_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_FILL: begin
        if (complete) begin
          // Unfilled upper slices of a partial word are still zero here.
          wdata_d = word_ins;
          waddr_d = addr_q;
          wr_d    = 1'b1;
          asm_d   = '0;
          slice_d = '0;
          cnt_d   = cnt_q + 1'b1;
          if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
          if (bus.in_last || addr_q == LAST_ADDR) begin
            state_d = S_LAST;
            ovf_d   = ~bus.in_last;
          end
        end else if (accept) begin
          asm_d   = word_ins;
          slice_d = slice_q + 1'b1;
        end
      end
      default: begin  // S_LAST: final write is on the port this cycle
        state_d = S_DONE;
        done_d  = 1'b1;
        full_d  = ovf_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      slice_q <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slice_q <= slice_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.bram_wr   = wr_q;
  assign bus.bram_addr = waddr_q;
  assign bus.bram_data = wdata_q;
  assign done_o        = done_q;
  assign full_o        = full_q;
  assign word_count_o  = cnt_q;
endmodule

// File: tb/tb_bram_stream_packer.sv
// Directed bench for bram_stream_packer with hand-computed expectations.
module tb_bram_stream_packer;
  localparam int IW = 2;
  localparam int WW = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic done, full;
  logic [AW:0] wcnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [AW-1:0] log_addr[$];
  logic [WW-1:0] log_data[$];

  bram_stream_packer_if #(.IN_WIDTH(IW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  bram_stream_packer #(.IN_WIDTH(IW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .bus          (bus),
    .done_o       (done),
    .full_o       (full),
    .word_count_o (wcnt)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.bram_wr === 1'b1) begin
      log_addr.push_back(bus.bram_addr);
      log_data.push_back(bus.bram_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Present a beat and hold it until accepted; returns 1 ns after the accept edge.
  task automatic send(input logic [IW-1:0] d, input logic l);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n >= 20, 0);
    tick(1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [AW-1:0] a, input logic [WW-1:0] d);
    if (idx < log_addr.size()) begin
      chk({tag, "_addr"}, log_addr[idx], a);
      chk({tag, "_data"}, log_data[idx], d);
    end else begin
      chk({tag, "_missing"}, idx, log_addr.size());
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  bus.in_ready,  0);
    chk({tag, "_wr"},   bus.bram_wr,   0);
    chk({tag, "_addr"}, bus.bram_addr, 0);
    chk({tag, "_data"}, bus.bram_data, 0);
    chk({tag, "_done"}, done,          0);
    chk({tag, "_full"}, full,          0);
    chk({tag, "_wcnt"}, wcnt,          0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    #23 rst = 1'b0;
    tick(1);
    chk_all_zero("reset");

    // Without start the packer stays idle and ignores beats.
    bus.in_valid = 1'b1;
    bus.in_data  = 2'd1;
    tick(3);
    chk("idle_rdy", bus.in_ready, 0);
    chk("idle_wr_cnt", log_addr.size(), 0);
    bus.in_valid = 1'b0;

    // Two full words: 1,2 -> 4'h9 ; 3,0 -> 4'h3
    clear_log();
    pulse_start();
    chk("a_rdy_after_start", bus.in_ready, 1);
    send(2'd1, 1'b0);
    send(2'd2, 1'b0);
    chk("a_wr0_strobe", bus.bram_wr, 1);
    chk("a_wr0_addr", bus.bram_addr, 0);
    chk("a_wr0_data", bus.bram_data, 4'h9);
    chk("a_rdy_during_wr", bus.in_ready, 1);
    send(2'd3, 1'b0);
    send(2'd0, 1'b1);
    chk("a_last_rdy", bus.in_ready, 0);
    chk("a_last_wr", bus.bram_wr, 1);
    chk("a_last_addr", bus.bram_addr, 1);
    chk("a_last_data", bus.bram_data, 4'h3);
    chk("a_done_early", done, 0);
    tick(1);
    chk("a_done", done, 1);
    chk("a_full", full, 0);
    chk("a_wcnt", wcnt, 2);
    chk("a_wr_off", bus.bram_wr, 0);
    chk("a_nwr", log_addr.size(), 2);
    chk_log("a_w0", 0, 3'd0, 4'h9);
    chk_log("a_w1", 1, 3'd1, 4'h3);

    // Partial word: 3,1 -> 4'h7 ; 2(last) -> 4'h2
    clear_log();
    pulse_start();
    chk("b_done_cleared", done, 0);
    chk("b_wcnt_cleared", wcnt, 0);
    send(2'd3, 1'b0);
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    tick(1);
    chk("b_done", done, 1);
    chk("b_full", full, 0);
    chk("b_wcnt", wcnt, 2);
    chk("b_nwr", log_addr.size(), 2);
    chk_log("b_w0", 0, 3'd0, 4'h7);
    chk_log("b_w1", 1, 3'd1, 4'h2);

    // Memory full: beats k&3 for k=0..15, even words 4'h4, odd words 4'hE.
    clear_log();
    pulse_start();
    for (int k = 0; k < 16; k++) send(IW'(k & 3), 1'b0);
    chk("c_rdy_after_16", bus.in_ready, 0);
    chk("c_last_wr", bus.bram_wr, 1);
    chk("c_last_addr", bus.bram_addr, 7);
    bus.in_valid = 1'b1;
    bus.in_data  = 2'd1;
    bus.in_last  = 1'b1;
    tick(1);
    chk("c_done", done, 1);
    chk("c_full", full, 1);
    chk("c_wcnt", wcnt, 8);
    tick(3);
    chk("c_17th_rdy", bus.in_ready, 0);
    chk("c_nwr", log_addr.size(), 8);
    chk("c_wcnt_hold", wcnt, 8);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int j = 0; j < 8; j++)
      chk_log("c_w", j, AW'(j), (j % 2) ? 4'hE : 4'h4);

    // Asynchronous reset mid-cycle with non-zero outputs.
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("post_rst_rdy", bus.in_ready, 0);

    // Stalls with a mid-fill start that must be ignored.
    clear_log();
    pulse_start();
    send(2'd1, 1'b0);
    tick(1);
    send(2'd2, 1'b0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    send(2'd3, 1'b0);
    tick(1);
    send(2'd0, 1'b1);
    tick(1);
    chk("d_done", done, 1);
    chk("d_full", full, 0);
    chk("d_wcnt", wcnt, 2);
    chk("d_nwr", log_addr.size(), 2);
    chk_log("d_w0", 0, 3'd0, 4'h9);
    chk_log("d_w1", 1, 3'd1, 4'h3);

    // Reset mid-word: stale slice must not survive.
    clear_log();
    pulse_start();
    send(2'd3, 1'b0);
    rst = 1'b1;
    #2 chk("e_rst_wr", bus.bram_wr, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    pulse_start();
    send(2'd1, 1'b0);
    send(2'd2, 1'b1);
    tick(1);
    chk("e_done", done, 1);
    chk("e_wcnt", wcnt, 1);
    chk("e_nwr", log_addr.size(), 1);
    chk_log("e_w0", 0, 3'd0, 4'h9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_stream_packer.md
# bram_stream_packer

Narrow-to-wide write-side packer for the BRAM library. Accepts a narrow valid/ready data stream, assembles consecutive beats into full-width words and drives a BRAM write port (wr/addr/data), one word per write, from address 0 upward. It is the writer that fills a wide-port BRAM which a narrow-port reader later unpacks. It reports completion, memory-full and the written word count.

## Interface
- IN_WIDTH, 2, narrow input beat width.
- WORD_WIDTH, 4, BRAM word width. Must be an integer multiple of IN_WIDTH, ratio ≥ 2.
- ADDR_WIDTH, 3, BRAM address width. Depth = 2**ADDR_WIDTH.
- RATIO (localparam) = WORD_WIDTH/IN_WIDTH, beats per word.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle pulse that arms a new fill. Ignored in FILL and LAST.
- in_data  in  IN_WIDTH  narrow beat.
- in_valid  in  1  beat present.
- in_last  in  1  final beat of the frame, qualified by in_valid.
- in_ready  out  1  packer accepts the beat; a beat transfers when in_valid & in_ready.
- bram_wr  out  1  write strobe, one cycle per word.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_data  out  WORD_WIDTH  assembled word.
- done  out  1  fill finished; held until the next start.
- full  out  1  fill ended because the last address was written without in_last; held until the next start.
- word_count  out  ADDR_WIDTH+1  number of words written since the last start.

## Operation
- **States and transitions:**
  - IDLE: in_ready=0. start → FILL.
  - FILL: in_ready=1.
    - An accepted beat completes a word when slice_cnt==RATIO-1, or when it carries in_last.
    - If that completing beat carries in_last, or the address counter equals DEPTH-1 → LAST.
    - Otherwise stay in FILL.
  - LAST: in_ready=0. The final write is issued. → DONE.
  - DONE: done=1, in_ready=0. start → FILL.
- **Start:** on start, addr_cnt, slice_cnt, the assembly register, word_count, done and full all clear to 0.
- **Packing:**
  - Beat k of a word goes to bits [k*IN_WIDTH +: IN_WIDTH]. The first beat lands in the LSBs.
  - slice_cnt counts 0..RATIO-1 and wraps to 0 after each completed word.
- **Partial word:** on in_last, unfilled upper slices are written as zero. The assembly register clears after every completed word.
- **Write:**
  - The completed word is copied into the bram_data register, with bram_addr=addr_cnt and bram_wr=1 for exactly one cycle.
  - addr_cnt and word_count then increment.
  - addr_cnt never wraps; reaching DEPTH-1 forces LAST.
- **Full flag:** full=1 in DONE only if the last word was written at address DEPTH-1 without in_last. If in_last coincides with address DEPTH-1, full=0.
- **Input while not ready:** in_valid is ignored whenever in_ready=0, including beats presented in LAST or DONE.

## Timing
- **Reset values:** all outputs are 0 (in_ready, bram_wr, bram_addr, bram_data, done, full, word_count). State is IDLE.
- **Start to ready:** start sampled at edge t gives in_ready=1 from cycle t+1.
- **Write latency:** a beat that completes a word, accepted at edge t, gives bram_wr=1 in cycle t+1. The write lands at the end of cycle t+1.
- **Throughput:**
  - One beat per cycle with no bubbles.
  - in_ready stays 1 during write cycles in FILL, so a new word assembles while the previous one is written.
  - Sustained rate is one word per RATIO cycles.
- **Final word:** the final beat is accepted at edge t. in_ready=0 from cycle t+1 (LAST, bram_wr=1). done=1 (and full, if applicable) from cycle t+2, so BRAM contents are complete when done rises.
- **Reset mid-operation:** outputs return to reset values immediately. No partial word is written, and the assembly register is lost.

## Structure
- **Shared package bram_pkg:**
  - State encoding: IDLE=2'd0, FILL=2'd1, LAST=2'd2, DONE=2'd3.
  - A clog2 function.
  - A ratio-check function, so the narrow-port reader and this writer share it.
- **Sub-module slice_demux** (parameters IN_WIDTH, WORD_WIDTH): combinational. Inserts in_data at slice index sel into a word, leaving the other slices untouched. The counters, FSM and output registers stay in the top module.

## Test plan
All scenarios use the defaults: IN_WIDTH=2, WORD_WIDTH=4, ADDR_WIDTH=3.
- **Reset:** assert rst asynchronously mid-cycle → every output reads 0 immediately. in_ready stays 0 without start.
- **Two full words:** start, then back-to-back beats 1,2,3,0 with in_last on 0 → bram_wr at addr 0 with data 4'h9, then addr 1 with data 4'h3. done=1 two cycles after the last accept, full=0, word_count=2.
- **Partial word:** start, beats 3,1,2 with in_last on 2 → writes 4'h7 @0 and 4'h2 @1 (upper slice zero-padded). done=1.
- **Memory full:** start, 16 beats with no in_last → 8 writes, addresses 0..7. in_ready=0 after the 16th accept. done=1, full=1, word_count=8. A 17th beat presented is not accepted.
- **Stalls and ignored start:** start, in_valid toggled 1/0 with the same beats as the two-full-words scenario, plus a start pulse mid-fill → identical writes and word_count=2. The mid-fill start has no effect.
- **Reset mid-word:** start, accept beat 3, assert rst, then start, beats 1,2 with in_last → a single write of 4'h9 @0. No stale slice appears, and no write occurs during reset.
